// File: rtl/execute_operand_select_if.sv
// Operand-select bus for the Y86-64 execute stage.
// The master drives the decoded instruction fields and register/immediate
// values; the slave returns the registered ALU operands and function code.
interface execute_operand_select_if #(
  parameter int WIDTH = 64
);
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;
  logic [WIDTH-1:0] valC;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic [1:0]       alufun;

  modport master (
    output icode,
    output ifun,
    output valA,
    output valB,
    output valC,
    input  aluA,
    input  aluB,
    input  alufun
  );

  modport slave (
    input  icode,
    input  ifun,
    input  valA,
    input  valB,
    input  valC,
    output aluA,
    output aluB,
    output alufun
  );
endinterface

// File: rtl/execute_operand_select.sv
// Execute-stage operand and function selector for the sequential Y86-64 core.
// Picks the two ALU operands and the ALU function from icode/ifun and the
// decode-stage values, and registers all three so the ALU sees stable inputs
// for a full cycle. Pure selection: no arithmetic, no sign-extension of valC.
module execute_operand_select #(
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  execute_operand_select_if.slave  bus
);

  // Instruction codes that influence selection.
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU function encodings.
  localparam logic [1:0] ALU_ADD = 2'b00;

  // Stack-pointer step constants, full-width two's complement.
  localparam logic [WIDTH-1:0] POS8 = WIDTH'(8);
  localparam logic [WIDTH-1:0] NEG8 = ~POS8 + WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  // aluA: register A for moves/OPq, immediate for irmovq and memory
  // displacement, -8/+8 for stack pointer adjust, zero otherwise.
  function automatic logic [WIDTH-1:0] sel_alu_a(
    input logic [3:0]       icode,
    input logic [WIDTH-1:0] val_a,
    input logic [WIDTH-1:0] val_c
  );
    logic [WIDTH-1:0] r;
    case (icode)
      I_RRMOVQ, I_OPQ:           r = val_a;
      I_IRMOVQ, I_RMMOVQ,
      I_MRMOVQ:                  r = val_c;
      I_CALL, I_PUSHQ:           r = NEG8;
      I_RET, I_POPQ:             r = POS8;
      default:                   r = ZERO;
    endcase
    return r;
  endfunction

  // aluB: register B (base address or %rsp) wherever it participates;
  // moves use zero so that valE equals aluA.
  function automatic logic [WIDTH-1:0] sel_alu_b(
    input logic [3:0]       icode,
    input logic [WIDTH-1:0] val_b
  );
    logic [WIDTH-1:0] r;
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ,
      I_CALL, I_RET, I_PUSHQ,
      I_POPQ:                    r = val_b;
      I_RRMOVQ, I_IRMOVQ:        r = ZERO;
      default:                   r = ZERO;
    endcase
    return r;
  endfunction

  // alufun: only OPq with a defined ifun selects a non-add operation;
  // address and stack arithmetic always adds.
  function automatic logic [1:0] sel_alu_fun(
    input logic [3:0] icode,
    input logic [3:0] ifun
  );
    logic [1:0] r;
    if ((icode == I_OPQ) && (ifun[3:2] == 2'b00)) begin
      r = ifun[1:0];
    end else begin
      r = ALU_ADD;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] aluA_d, aluA_q;
  logic [WIDTH-1:0] aluB_d, aluB_q;
  logic [1:0]       alufun_d, alufun_q;

  // Next-value selection from the current inputs.
  always_comb begin
    aluA_d   = sel_alu_a(bus.icode, bus.valA, bus.valC);
    aluB_d   = sel_alu_b(bus.icode, bus.valB);
    alufun_d = sel_alu_fun(bus.icode, bus.ifun);
  end

  // Single output register stage; reset overrides the sampled operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      aluA_q   <= ZERO;
      aluB_q   <= ZERO;
      alufun_q <= ALU_ADD;
    end else begin
      aluA_q   <= aluA_d;
      aluB_q   <= aluB_d;
      alufun_q <= alufun_d;
    end
  end

  assign bus.aluA   = aluA_q;
  assign bus.aluB   = aluB_q;
  assign bus.alufun = alufun_q;

  // Codes that deliberately fall through to the zero/add defaults.
  logic unused_codes;
  assign unused_codes = ^{I_HALT, I_NOP, I_JXX};

endmodule

// File: tb/tb_execute_operand_select.sv
// Self-checking bench for execute_operand_select: directed scenarios from the
// instruction set rules plus randomized traffic against a behavioural model.
module tb_execute_operand_select;

  localparam int W = 64;
  localparam logic [W-1:0] M8 = 64'hFFFF_FFFF_FFFF_FFF8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  execute_operand_select_if #(.WIDTH(W)) bus ();

  execute_operand_select #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural reference: which source each instruction class uses.
  function automatic logic [W-1:0] m_alu_a(input logic [3:0] ic,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] c);
    if (ic == 4'h2 || ic == 4'h6) return a;
    if (ic >= 4'h3 && ic <= 4'h5) return c;
    if (ic == 4'h8 || ic == 4'hA) return 64'd0 - 64'd8;
    if (ic == 4'h9 || ic == 4'hB) return 64'd8;
    return '0;
  endfunction

  function automatic logic [W-1:0] m_alu_b(input logic [3:0] ic,
                                           input logic [W-1:0] b);
    if (ic >= 4'h4 && ic <= 4'hB && ic != 4'h7) return b;
    return '0;
  endfunction

  function automatic logic [1:0] m_alu_fun(input logic [3:0] ic,
                                           input logic [3:0] fn);
    if (ic == 4'h6 && fn < 4) return fn[1:0];
    return 2'b00;
  endfunction

  // Drive one set of inputs, then step past the next rising edge.
  task automatic apply(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c);
    bus.icode = ic;
    bus.ifun  = fn;
    bus.valA  = a;
    bus.valB  = b;
    bus.valC  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(4'h6, 4'h1, 64'd30, 64'd50, 64'd20);
      checks++;
      if (bus.aluA !== 64'd0) begin
        failures++;
        $display("FAIL reset_aluA cyc=%0d got=%h exp=0", i, bus.aluA);
      end
      checks++;
      if (bus.aluB !== 64'd0) begin
        failures++;
        $display("FAIL reset_aluB cyc=%0d got=%h exp=0", i, bus.aluB);
      end
      checks++;
      if (bus.alufun !== 2'b00) begin
        failures++;
        $display("FAIL reset_alufun cyc=%0d got=%b exp=00", i, bus.alufun);
      end
    end
    reset = 1'b0;
    apply(4'h6, 4'h0, 64'd30, 64'd50, 64'd20);
    checks++;
    if (bus.aluA !== 64'd30) begin
      failures++;
      $display("FAIL reset_release_aluA got=%0d exp=30", bus.aluA);
    end
  endtask

  task automatic test_opq();
    logic [3:0] fns [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5};
    logic [1:0] exp [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 5; i++) begin
      apply(4'h6, fns[i], 64'd30, 64'd50, 64'd99);
      checks++;
      if (bus.aluA !== 64'd30 || bus.aluB !== 64'd50) begin
        failures++;
        $display("FAIL opq_operands ifun=%0d got=%0d/%0d exp=30/50",
                 fns[i], bus.aluA, bus.aluB);
      end
      checks++;
      if (bus.alufun !== exp[i]) begin
        failures++;
        $display("FAIL opq_alufun ifun=%0d got=%b exp=%b",
                 fns[i], bus.alufun, exp[i]);
      end
    end
  endtask

  task automatic test_moves();
    logic [3:0]   ic [4] = '{4'h3, 4'h4, 4'h5, 4'h2};
    logic [W-1:0] va [4] = '{64'd11, 64'd12, 64'd13, 64'd30};
    logic [W-1:0] vc [4] = '{64'd20, 64'd35, 64'd70, 64'd44};
    logic [W-1:0] ea [4] = '{64'd20, 64'd35, 64'd70, 64'd30};
    logic [W-1:0] eb [4] = '{64'd0,  64'd50, 64'd50, 64'd0};
    for (int i = 0; i < 4; i++) begin
      apply(ic[i], 4'h2, va[i], 64'd50, vc[i]);
      checks++;
      if (bus.aluA !== ea[i] || bus.aluB !== eb[i] || bus.alufun !== 2'b00) begin
        failures++;
        $display("FAIL move icode=%h got=%0d/%0d/%b exp=%0d/%0d/00",
                 ic[i], bus.aluA, bus.aluB, bus.alufun, ea[i], eb[i]);
      end
    end
  endtask

  task automatic test_stack();
    logic [3:0]   ic [4] = '{4'hA, 4'hB, 4'h8, 4'h9};
    logic [W-1:0] ea [4] = '{M8, 64'd8, M8, 64'd8};
    for (int i = 0; i < 4; i++) begin
      apply(ic[i], 4'h3, 64'd30, 64'd50, 64'd77);
      checks++;
      if (bus.aluA !== ea[i] || bus.aluB !== 64'd50 || bus.alufun !== 2'b00) begin
        failures++;
        $display("FAIL stack icode=%h got=%h/%0d/%b exp=%h/50/00",
                 ic[i], bus.aluA, bus.aluB, bus.alufun, ea[i]);
      end
    end
  endtask

  task automatic test_non_alu();
    logic [3:0] ic [7] = '{4'h0, 4'h1, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int i = 0; i < 7; i++) begin
      apply(ic[i], 4'h1, 64'd123, 64'd456, 64'd789);
      checks++;
      if (bus.aluA !== 64'd0 || bus.aluB !== 64'd0 || bus.alufun !== 2'b00) begin
        failures++;
        $display("FAIL non_alu icode=%h got=%0d/%0d/%b exp=0/0/00",
                 ic[i], bus.aluA, bus.aluB, bus.alufun);
      end
    end
  endtask

  task automatic test_hold();
    apply(4'h6, 4'h3, 64'd1000, 64'd2000, 64'd3000);
    bus.icode = 4'hA;
    bus.ifun  = 4'h0;
    bus.valA  = 64'd5;
    bus.valB  = 64'd6;
    #3;
    bus.icode = 4'h3;
    bus.valC  = 64'd9;
    #1;
    checks++;
    if (bus.aluA !== 64'd1000 || bus.aluB !== 64'd2000 || bus.alufun !== 2'b11) begin
      failures++;
      $display("FAIL hold got=%0d/%0d/%b exp=1000/2000/11",
               bus.aluA, bus.aluB, bus.alufun);
    end
  endtask

  task automatic test_midstream_reset();
    logic [3:0] ic;
    for (int i = 0; i < 6; i++) begin
      ic = (i % 2 == 0) ? 4'h6 : 4'hA;
      apply(ic, 4'(i % 4), 64'(100 + i), 64'(200 + i), 64'd7);
      checks++;
      if (bus.aluA !== m_alu_a(ic, 64'(100 + i), 64'd7) ||
          bus.aluB !== 64'(200 + i) ||
          bus.alufun !== m_alu_fun(ic, 4'(i % 4))) begin
        failures++;
        $display("FAIL mid_pre cyc=%0d got=%h/%0d/%b", i, bus.aluA, bus.aluB, bus.alufun);
      end
    end
    reset = 1'b1;
    apply(4'h6, 4'h1, 64'd300, 64'd400, 64'd7);
    reset = 1'b0;
    checks++;
    if (bus.aluA !== 64'd0 || bus.aluB !== 64'd0 || bus.alufun !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset got=%0d/%0d/%b exp=0/0/00", bus.aluA, bus.aluB, bus.alufun);
    end
    apply(4'hA, 4'h0, 64'd300, 64'd400, 64'd7);
    checks++;
    if (bus.aluA !== M8 || bus.aluB !== 64'd400 || bus.alufun !== 2'b00) begin
      failures++;
      $display("FAIL mid_resume got=%h/%0d/%b exp=%h/400/00", bus.aluA, bus.aluB, bus.alufun, M8);
    end
  endtask

  task automatic test_random();
    logic [3:0]   ic, fn;
    logic [W-1:0] a, b, c;
    for (int i = 0; i < 300; i++) begin
      ic = 4'($urandom_range(0, 15));
      fn = 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      c  = {$urandom, $urandom};
      apply(ic, fn, a, b, c);
      checks++;
      if (bus.aluA !== m_alu_a(ic, a, c) || bus.aluB !== m_alu_b(ic, b) ||
          bus.alufun !== m_alu_fun(ic, fn)) begin
        failures++;
        $display("FAIL random i=%0d icode=%h ifun=%h got=%h/%h/%b exp=%h/%h/%b",
                 i, ic, fn, bus.aluA, bus.aluB, bus.alufun,
                 m_alu_a(ic, a, c), m_alu_b(ic, b), m_alu_fun(ic, fn));
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.icode = '0;
    bus.ifun  = '0;
    bus.valA  = '0;
    bus.valB  = '0;
    bus.valC  = '0;
    #1;
    test_reset();
    test_opq();
    test_moves();
    test_stack();
    test_non_alu();
    test_hold();
    test_midstream_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
